// File: rtl/serial_comp_pkg.sv
// serial_comp_pkg: shared state encoding and default word width for the serial comparators.
package serial_comp_pkg;
    typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/bit_cmp_cell.sv
// bit_cmp_cell: one-bit unsigned compare of an x/y bit pair.
module bit_cmp_cell (
    input  logic x,
    input  logic y,
    output logic bit_eq,
    output logic bit_gt
);
    assign bit_eq = ~(x ^ y);
    assign bit_gt = x & ~y;
endmodule

// File: rtl/serial_comp.sv
// serial_comp: MSB-first bit-serial unsigned comparator producing one eq/gt/lt result per word.
module serial_comp
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    output logic in_ready,
    input  logic x,
    input  logic y,
    output logic out_valid,
    input  logic out_ready,
    output logic eq,
    output logic gt,
    output logic lt
);
    localparam int CNT_W = $clog2(WIDTH);

    state_t state;
    logic [CNT_W-1:0] cnt;
    logic decided;
    logic bit_eq;
    logic bit_gt;
    logic bit_lt;

    bit_cmp_cell u_cell (
        .x      (x),
        .y      (y),
        .bit_eq (bit_eq),
        .bit_gt (bit_gt)
    );

    assign bit_lt   = ~bit_eq & ~bit_gt;
    assign in_ready = (state == ST_ACC);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= ST_ACC;
            cnt       <= '0;
            decided   <= 1'b0;
            out_valid <= 1'b0;
            eq        <= 1'b1;
            gt        <= 1'b0;
            lt        <= 1'b0;
        end else if (state == ST_ACC) begin
            if (in_valid) begin
                // Only the first differing bit from the MSB sets the ordering.
                if (!decided && !bit_eq) begin
                    decided <= 1'b1;
                    eq      <= 1'b0;
                    gt      <= bit_gt;
                    lt      <= bit_lt;
                end
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    cnt       <= '0;
                    state     <= ST_HOLD;
                    out_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else if (out_ready) begin
            state     <= ST_ACC;
            out_valid <= 1'b0;
            decided   <= 1'b0;
            eq        <= 1'b1;
            gt        <= 1'b0;
            lt        <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_comp.sv
// tb_serial_comp: directed and randomized checks of serial_comp against a word-level model.
module tb_serial_comp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic x = 1'b0;
    logic y = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic eq;
    logic gt;
    logic lt;
    int tests = 0;
    int fails = 0;

    serial_comp #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    // Drives bits hi..lo of a/b back-to-back; starts and ends 1 time unit after a rising edge.
    task automatic send_bits(input logic [7:0] a, input logic [7:0] b, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            in_valid = 1'b1;
            x = a[i];
            y = b[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({out_valid, in_ready, eq, gt, lt} !== 5'b01100) begin
                fails++;
                $display("FAIL reset_idle cycle %0d: got ov/ir/eq/gt/lt=%b exp 01100", c,
                         {out_valid, in_ready, eq, gt, lt});
            end
        end
    endtask

    task automatic test_directed;
        logic [7:0] av [3];
        logic [7:0] bv [3];
        logic [2:0] exp;
        logic part_eq;
        av = '{8'hA5, 8'h80, 8'h3C};
        bv = '{8'hA5, 8'h7F, 8'h3D};
        for (int k = 0; k < 3; k++) begin
            exp = {av[k] == bv[k], av[k] > bv[k], av[k] < bv[k]};
            part_eq = (av[k][7:1] == bv[k][7:1]);
            send_bits(av[k], bv[k], 7, 1);
            tests++;
            if (out_valid !== 1'b0 || eq !== part_eq) begin
                fails++;
                $display("FAIL directed_%0d_partial: got ov=%b eq=%b exp ov=0 eq=%b", k, out_valid, eq, part_eq);
            end
            send_bits(av[k], bv[k], 0, 0);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {eq, gt, lt} !== exp) begin
                fails++;
                $display("FAIL directed_%0d_result: got ov=%b ir=%b eqgtlt=%b exp ov=1 ir=0 eqgtlt=%b",
                         k, out_valid, in_ready, {eq, gt, lt}, exp);
            end
            out_ready = 1'b1;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid = 1'b0;
            tests++;
            if ({out_valid, in_ready, eq, gt, lt} !== 5'b01100) begin
                fails++;
                $display("FAIL directed_%0d_release: got ov/ir/eq/gt/lt=%b exp 01100", k,
                         {out_valid, in_ready, eq, gt, lt});
            end
        end
    endtask

    task automatic test_backpressure;
        send_bits(8'hC3, 8'h5A, 7, 0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            x = 1'($urandom);
            y = 1'($urandom);
            @(posedge clk);
            #1;
            tests++;
            if ({out_valid, in_ready, eq, gt, lt} !== 5'b10010) begin
                fails++;
                $display("FAIL backpressure cycle %0d: got ov/ir/eq/gt/lt=%b exp 10010", c,
                         {out_valid, in_ready, eq, gt, lt});
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests++;
        if ({out_valid, in_ready, eq, gt, lt} !== 5'b01100) begin
            fails++;
            $display("FAIL backpressure_release: got ov/ir/eq/gt/lt=%b exp 01100",
                     {out_valid, in_ready, eq, gt, lt});
        end
    endtask

    task automatic test_clr;
        for (int m = 0; m < 3; m++) begin
            if (m < 2) begin
                send_bits(8'hFF, 8'h00, 7, 4);
                tests++;
                if ({eq, gt, lt} !== 3'b010) begin
                    fails++;
                    $display("FAIL clr_%0d_pre: got eqgtlt=%b exp 010", m, {eq, gt, lt});
                end
            end else begin
                send_bits(8'hFF, 8'h00, 7, 0);
                tests++;
                if ({out_valid, eq, gt, lt} !== 4'b1010) begin
                    fails++;
                    $display("FAIL clr_%0d_pre: got ov/eq/gt/lt=%b exp 1010", m, {out_valid, eq, gt, lt});
                end
                out_ready = 1'b1;
            end
            if (m == 1) rst = 1'b1;
            else clr = 1'b1;
            in_valid = 1'b1;
            x = 1'b1;
            y = 1'b0;
            @(posedge clk);
            #1;
            clr = 1'b0;
            rst = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b0;
            tests++;
            if ({out_valid, in_ready, eq, gt, lt} !== 5'b01100) begin
                fails++;
                $display("FAIL clr_%0d_flush: got ov/ir/eq/gt/lt=%b exp 01100", m,
                         {out_valid, in_ready, eq, gt, lt});
            end
            send_bits(8'h01, 8'h01, 7, 1);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL clr_%0d_early: got ov=%b exp 0", m, out_valid);
            end
            send_bits(8'h01, 8'h01, 0, 0);
            tests++;
            if ({out_valid, eq, gt, lt} !== 4'b1100) begin
                fails++;
                $display("FAIL clr_%0d_next_word: got ov/eq/gt/lt=%b exp 1100", m, {out_valid, eq, gt, lt});
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_random;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] exp;
        int sel;
        for (int w = 0; w < 200; w++) begin
            a = 8'($urandom);
            sel = int'($urandom_range(0, 3));
            b = (sel == 0) ? a : (sel == 1) ? (a ^ (8'h01 << $urandom_range(0, 7))) : 8'($urandom);
            exp = {a == b, a > b, a < b};
            for (int i = 7; i >= 0; i--) begin
                while ($urandom_range(0, 1) == 1) begin
                    in_valid = 1'b0;
                    x = 1'($urandom);
                    y = 1'($urandom);
                    @(posedge clk);
                    #1;
                    tests++;
                    if (!$onehot({eq, gt, lt}) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                        fails++;
                        $display("FAIL random_gap w%0d: got ov/ir/eq/gt/lt=%b", w,
                                 {out_valid, in_ready, eq, gt, lt});
                    end
                end
                in_valid = 1'b1;
                x = a[i];
                y = b[i];
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                tests++;
                if (!$onehot({eq, gt, lt}) || out_valid !== (i == 0)) begin
                    fails++;
                    $display("FAIL random_bit w%0d b%0d: got ov/eq/gt/lt=%b exp ov=%b one-hot", w, i,
                             {out_valid, eq, gt, lt}, i == 0);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            tests++;
            if (out_valid !== 1'b1 || {eq, gt, lt} !== exp) begin
                fails++;
                $display("FAIL random_result w%0d X=%h Y=%h: got ov=%b eqgtlt=%b exp ov=1 eqgtlt=%b",
                         w, a, b, out_valid, {eq, gt, lt}, exp);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            tests++;
            if ({out_valid, eq, gt, lt} !== 4'b0100) begin
                fails++;
                $display("FAIL random_release w%0d: got ov/eq/gt/lt=%b exp 0100", w, {out_valid, eq, gt, lt});
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
